// File: rtl/urv_irq_ctrl_if.sv
// Configuration bus and interrupt handshake between the core and urv_irq_ctrl.
// master = core side, slave = interrupt controller side.
interface urv_irq_ctrl_if;
   logic        cfg_we_i;
   logic [2:0]  cfg_addr_i;
   logic [31:0] cfg_wdata_i;
   logic [31:0] cfg_rdata_o;
   logic        irq_o;
   logic [2:0]  irq_id_o;
   logic        irq_ack_i;
   logic        tick_o;

   modport master (
      output cfg_we_i, cfg_addr_i, cfg_wdata_i, irq_ack_i,
      input  cfg_rdata_o, irq_o, irq_id_o, tick_o
   );

   modport slave (
      input  cfg_we_i, cfg_addr_i, cfg_wdata_i, irq_ack_i,
      output cfg_rdata_o, irq_o, irq_id_o, tick_o
   );
endinterface

// File: rtl/urv_irq_ctrl.sv
// urv_irq_ctrl: 8-source fixed-priority interrupt controller with a
// one-outstanding request handshake and a programmable timer tick.
// Optional feature macro: URV_IRQ_EDGE_EN adds edge-triggered sources
// (EDGE register, sticky pending bits, W1C clear on PENDING). Without it
// every source is level-sensitive and no edge flops exist.
// Register map: 0 ENABLE, 1 PENDING, 2 EDGE, 3 ACTIVE/EOI, 4 TICK_DIV.
module urv_irq_ctrl #(
   parameter logic [15:0] TICK_DIV_RST = 16'd0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] irq_i,
   urv_irq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic        irq_reg;
   logic [2:0]  irq_id_reg, irq_id_next;
   logic [7:0]  enable_reg;
   logic [15:0] tick_div_reg;
   logic [15:0] tick_cnt_reg;
   logic        tick_reg;

   logic [7:0]  pending;
   logic [7:0]  eligible;
   logic [7:0]  edge_rd;
   logic [2:0]  sel_id;
   logic        wr_enable, wr_eoi, wr_tick_div;
   logic        ack_take;
   logic        unused_wdata;

   assign wr_enable   = bus.cfg_we_i && (bus.cfg_addr_i == 3'd0);
   assign wr_eoi      = bus.cfg_we_i && (bus.cfg_addr_i == 3'd3);
   assign wr_tick_div = bus.cfg_we_i && (bus.cfg_addr_i == 3'd4);
   assign ack_take    = (state_reg == ST_REQ) && bus.irq_ack_i;

   // Upper write-data bits are not backed by any register.
   assign unused_wdata = ^bus.cfg_wdata_i[31:16];

`ifdef URV_IRQ_EDGE_EN
   logic [7:0] edge_reg;
   logic [7:0] irq_d_reg;
   logic [7:0] sticky_reg, sticky_next;
   logic [7:0] edge_set, ack_clr, w1c_clr;
   logic       wr_edge, wr_pending;

   assign wr_edge    = bus.cfg_we_i && (bus.cfg_addr_i == 3'd2);
   assign wr_pending = bus.cfg_we_i && (bus.cfg_addr_i == 3'd1);

   // Per-source sticky bookkeeping: a new edge always beats a clear.
   for (genvar gi = 0; gi < 8; gi++) begin : g_sticky
      assign edge_set[gi]    = edge_reg[gi] && irq_i[gi] && !irq_d_reg[gi];
      assign ack_clr[gi]     = ack_take && (irq_id_reg == 3'(gi));
      assign w1c_clr[gi]     = wr_pending && bus.cfg_wdata_i[gi];
      assign sticky_next[gi] = edge_reg[gi] &&
                               (edge_set[gi] || (sticky_reg[gi] && !ack_clr[gi] && !w1c_clr[gi]));
   end

   // Edge-source state: registered input copy, EDGE register, sticky pending.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         edge_reg   <= '0;
         irq_d_reg  <= '0;
         sticky_reg <= '0;
      end else begin
         irq_d_reg  <= irq_i;
         sticky_reg <= sticky_next;
         if (wr_edge)
            edge_reg <= bus.cfg_wdata_i[7:0];
      end
   end

   assign pending = (sticky_reg & edge_reg) | (irq_i & ~edge_reg);
   assign edge_rd = edge_reg;
`else
   assign pending = irq_i;
   assign edge_rd = '0;
`endif

   assign eligible = pending & enable_reg;

   // Lowest eligible index wins (source 0 is highest priority).
   always_comb begin
      sel_id = '0;
      for (int i = 7; i >= 0; i--) begin
         if (eligible[i])
            sel_id = 3'(i);
      end
   end

   // Request FSM next-state: one interrupt in flight, no nesting.
   always_comb begin
      state_next  = state_reg;
      irq_id_next = irq_id_reg;
      case (state_reg)
         ST_IDLE: begin
            if (eligible != '0) begin
               state_next  = ST_REQ;
               irq_id_next = sel_id;
            end
         end
         ST_REQ: begin
            if (bus.irq_ack_i) begin
               state_next = ST_ACTIVE;
            end else if (eligible == '0) begin
               state_next = ST_IDLE;
            end else begin
               irq_id_next = sel_id;
            end
         end
         ST_ACTIVE: begin
            if (wr_eoi)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM state register and registered request outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg  <= ST_IDLE;
         irq_reg    <= 1'b0;
         irq_id_reg <= '0;
      end else begin
         state_reg  <= state_next;
         irq_reg    <= (state_next == ST_REQ);
         irq_id_reg <= irq_id_next;
      end
   end

   // ENABLE and TICK_DIV configuration registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         enable_reg   <= '0;
         tick_div_reg <= TICK_DIV_RST;
      end else begin
         if (wr_enable)
            enable_reg <= bus.cfg_wdata_i[7:0];
         if (wr_tick_div)
            tick_div_reg <= bus.cfg_wdata_i[15:0];
      end
   end

   // Tick counter: counts 0..TICK_DIV, pulses on wrap; idle when TICK_DIV is 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tick_cnt_reg <= '0;
         tick_reg     <= 1'b0;
      end else if (wr_tick_div || (tick_div_reg == '0)) begin
         tick_cnt_reg <= '0;
         tick_reg     <= 1'b0;
      end else if (tick_cnt_reg == tick_div_reg) begin
         tick_cnt_reg <= '0;
         tick_reg     <= 1'b1;
      end else begin
         tick_cnt_reg <= tick_cnt_reg + 16'd1;
         tick_reg     <= 1'b0;
      end
   end

   // Combinational register read mux; unmapped addresses read zero.
   always_comb begin
      bus.cfg_rdata_o = '0;
      case (bus.cfg_addr_i)
         3'd0: bus.cfg_rdata_o = {24'h0, enable_reg};
         3'd1: bus.cfg_rdata_o = {24'h0, pending};
         3'd2: bus.cfg_rdata_o = {24'h0, edge_rd};
         3'd3: bus.cfg_rdata_o = {(state_reg == ST_ACTIVE), 28'h0, irq_id_reg};
         3'd4: bus.cfg_rdata_o = {16'h0, tick_div_reg};
         default: bus.cfg_rdata_o = '0;
      endcase
   end

   assign bus.irq_o    = irq_reg;
   assign bus.irq_id_o = irq_id_reg;
   assign bus.tick_o   = tick_reg;

endmodule
